// File: rtl/boot_loader_if.sv
// Image stream plus memory write port shared by the boot loader, its source and the CPU memories.
// The slave view is the loader; the master view is whatever feeds the image and observes writes.
interface boot_loader_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Parses a sectioned, checksummed boot image into instruction/data memory writes and
// releases the CPU reset only after the whole image has been verified.
module boot_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [15:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic        r_sel;
  logic [14:0] r_count;
  logic [15:0] r_addr;
  logic [15:0] r_sum;
  logic [31:0] r_tmo;
  logic        r_mem_we;
  logic        r_mem_sel;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_cpu_rst_n;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [15:0] r_words;

  logic        w_active;
  logic        w_timed;
  logic        w_xfer;
  logic        w_tmo_hit;
  logic [15:0] w_sum_next;
  logic [16:0] w_range_end;

  assign w_active    = (r_state == S_HDR) || (r_state == S_ADDR) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timed     = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_xfer      = bus.in_valid & w_active;
  assign w_sum_next  = r_sum + bus.in_data;
  assign w_range_end = {1'b0, bus.in_data} + {2'b00, r_count};
  // The idle cycle that would bring the count up to TIMEOUT is the one that faults.
  assign w_tmo_hit   = (TIMEOUT != 0) && w_timed && !w_xfer && (r_tmo == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HDR;
      r_sel       <= 1'b0;
      r_count     <= '0;
      r_addr      <= '0;
      r_sum       <= '0;
      r_tmo       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_sel   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
      r_words     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_timed && !w_xfer) r_tmo <= r_tmo + 32'd1;
      else                    r_tmo <= '0;

      if (w_tmo_hit) begin
        r_state    <= S_ERR;
        r_err      <= 1'b1;
        r_err_code <= 2'b11;
      end else if (w_xfer) begin
        case (r_state)
          S_HDR: begin
            if (bus.in_data == 16'h0000) begin
              r_state <= S_CSUM;
            end else if (bus.in_data == 16'h8000) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= 2'b10;
            end else begin
              r_sel   <= bus.in_data[15];
              r_count <= bus.in_data[14:0];
              r_state <= S_ADDR;
            end
          end
          S_ADDR: begin
            // A section may end exactly at the top of the 64K address space but not past it.
            if (w_range_end > 17'h10000) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= 2'b10;
            end else begin
              r_addr  <= bus.in_data;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_sel   <= r_sel;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= bus.in_data;
            r_addr      <= r_addr + 16'd1;
            r_sum       <= w_sum_next;
            r_count     <= r_count - 15'd1;
            if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
            if (r_count == 15'd1) r_state <= S_HDR;
          end
          S_CSUM: begin
            if (w_sum_next == 16'h0000) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= 2'b01;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign bus.in_ready  = w_active;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign cpu_rst_n     = r_cpu_rst_n;
  assign done          = r_done;
  assign err           = r_err;
  assign err_code      = r_err_code;
  assign words_loaded  = r_words;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: image parsing, write timing, checksum, range errors,
// timeout behaviour and mid-load reset, with hand-computed expectations.
module tb_boot_loader;
  logic        clk;
  logic        rst;
  logic        cpuRstN;
  logic        done;
  logic        err;
  logic [1:0]  errCode;
  logic [15:0] wordsLoaded;
  int          nChecks;
  int          nFails;
  int          weCount;

  boot_loader_if bif ();

  boot_loader #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bif.slave),
    .cpu_rst_n    (cpuRstN),
    .done         (done),
    .err          (err),
    .err_code     (errCode),
    .words_loaded (wordsLoaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every write strobe cycle, sampled mid-cycle.
  always @(negedge clk) if (bif.mem_we === 1'b1) weCount++;

  task automatic doReset();
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    weCount = 0;
  endtask

  // Presents one word and returns 1ns after the edge on which it was taken.
  task automatic applyStimulus(input logic [15:0] w);
    bit took;
    took = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data = w;
    for (int k = 0; k < 16 && !took; k++) begin
      took = (bif.in_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    bif.in_valid = 1'b0;
    nChecks++;
    if (!took) begin
      nFails++;
      $display("FAIL accept: word %h got in_ready low, expected acceptance", w);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    doReset();
    nChecks++;
    if ({bif.in_ready, bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      nFails++;
      $display("FAIL reset_bus: got rdy=%b we=%b sel=%b addr=%h wd=%h, expected 1 0 0 0000 0000",
               bif.in_ready, bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata);
    end
    nChecks++;
    if ({cpuRstN, done, err, errCode, wordsLoaded} !== {1'b0, 1'b0, 1'b0, 2'b00, 16'h0}) begin
      nFails++;
      $display("FAIL reset_status: got cpu_rst_n=%b done=%b err=%b code=%b words=%h, expected 0 0 0 00 0000",
               cpuRstN, done, err, errCode, wordsLoaded);
    end
  endtask

  task automatic test_single_section();
    logic [15:0] dat [3];
    dat = '{16'hA1B2, 16'h0004, 16'h0005};
    doReset();
    applyStimulus(16'h0003);
    applyStimulus(16'h0010);
    nChecks++;
    if (bif.mem_we !== 1'b0) begin
      nFails++;
      $display("FAIL s1_no_hdr_write: got mem_we=%b, expected 0", bif.mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(dat[i]);
      nChecks++;
      if ({bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata} !== {1'b1, 1'b0, 16'h0010 + 16'(i), dat[i]}) begin
        nFails++;
        $display("FAIL s1_write%0d: got we=%b sel=%b addr=%h wd=%h, expected 1 0 %h %h", i,
                 bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata, 16'h0010 + 16'(i), dat[i]);
      end
    end
    applyStimulus(16'h0000);
    nChecks++;
    if ({cpuRstN, done, bif.mem_we} !== 3'b000) begin
      nFails++;
      $display("FAIL s1_endmark: got cpu_rst_n=%b done=%b we=%b, expected 0 0 0", cpuRstN, done, bif.mem_we);
    end
    applyStimulus(16'h5E45);
    nChecks++;
    if ({done, cpuRstN, err, bif.in_ready, wordsLoaded} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd3}) begin
      nFails++;
      $display("FAIL s1_done: got done=%b cpu_rst_n=%b err=%b rdy=%b words=%h, expected 1 1 0 0 0003",
               done, cpuRstN, err, bif.in_ready, wordsLoaded);
    end
    nChecks++;
    if (weCount !== 3) begin
      nFails++;
      $display("FAIL s1_wecount: got %0d write pulses, expected 3", weCount);
    end
  endtask

  task automatic test_two_sections_gap();
    logic [15:0] dat [4];
    logic [15:0] adr [4];
    logic        sel [4];
    dat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    adr = '{16'h0000, 16'h0001, 16'h0100, 16'h0101};
    sel = '{1'b0, 1'b0, 1'b1, 1'b1};
    doReset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin applyStimulus(16'h0002); applyStimulus(16'h0000); end
      if (i == 2) begin applyStimulus(16'h8002); applyStimulus(16'h0100); end
      applyStimulus(dat[i]);
      nChecks++;
      if ({bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata} !== {1'b1, sel[i], adr[i], dat[i]}) begin
        nFails++;
        $display("FAIL s2_write%0d: got we=%b sel=%b addr=%h wd=%h, expected 1 %b %h %h", i,
                 bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata, sel[i], adr[i], dat[i]);
      end
      if (i == 2) begin
        for (int g = 0; g < 3; g++) begin
          idleCycles(1);
          nChecks++;
          if (bif.mem_we !== 1'b0) begin
            nFails++;
            $display("FAIL s2_gap%0d: got mem_we=%b, expected 0", g, bif.mem_we);
          end
        end
      end
    end
    applyStimulus(16'h0000);
    applyStimulus(16'h5556);
    nChecks++;
    if ({done, cpuRstN, err, wordsLoaded} !== {1'b1, 1'b1, 1'b0, 16'd4}) begin
      nFails++;
      $display("FAIL s2_done: got done=%b cpu_rst_n=%b err=%b words=%h, expected 1 1 0 0004",
               done, cpuRstN, err, wordsLoaded);
    end
    nChecks++;
    if (weCount !== 4) begin
      nFails++;
      $display("FAIL s2_wecount: got %0d write pulses, expected 4", weCount);
    end
  endtask

  task automatic test_bad_checksum();
    doReset();
    applyStimulus(16'h0003);
    applyStimulus(16'h0010);
    applyStimulus(16'hA1B2);
    applyStimulus(16'h0004);
    applyStimulus(16'h0005);
    applyStimulus(16'h0000);
    applyStimulus(16'h5E44);
    nChecks++;
    if ({err, errCode, cpuRstN, done, bif.in_ready} !== {1'b1, 2'b01, 1'b0, 1'b0, 1'b0}) begin
      nFails++;
      $display("FAIL csum_err: got err=%b code=%b cpu_rst_n=%b done=%b rdy=%b, expected 1 01 0 0 0",
               err, errCode, cpuRstN, done, bif.in_ready);
    end
    bif.in_valid = 1'b1;
    bif.in_data = 16'h0000;
    idleCycles(5);
    bif.in_valid = 1'b0;
    nChecks++;
    if ({err, errCode, cpuRstN} !== {1'b1, 2'b01, 1'b0}) begin
      nFails++;
      $display("FAIL csum_sticky: got err=%b code=%b cpu_rst_n=%b, expected 1 01 0", err, errCode, cpuRstN);
    end
  endtask

  task automatic test_range();
    doReset();
    applyStimulus(16'h8004);
    nChecks++;
    if (err !== 1'b0) begin
      nFails++;
      $display("FAIL range_early: got err=%b after header, expected 0", err);
    end
    applyStimulus(16'hFFFE);
    nChecks++;
    if ({err, errCode, bif.in_ready} !== {1'b1, 2'b10, 1'b0}) begin
      nFails++;
      $display("FAIL range_err: got err=%b code=%b rdy=%b, expected 1 10 0", err, errCode, bif.in_ready);
    end
    idleCycles(3);
    nChecks++;
    if (weCount !== 0) begin
      nFails++;
      $display("FAIL range_nowrite: got %0d write pulses, expected 0", weCount);
    end

    doReset();
    applyStimulus(16'h8000);
    nChecks++;
    if ({err, errCode} !== {1'b1, 2'b10}) begin
      nFails++;
      $display("FAIL fmt_err: got err=%b code=%b, expected 1 10", err, errCode);
    end

    doReset();
    applyStimulus(16'h8002);
    applyStimulus(16'hFFFE);
    applyStimulus(16'h0001);
    nChecks++;
    if ({err, bif.mem_we, bif.mem_sel, bif.mem_addr} !== {1'b0, 1'b1, 1'b1, 16'hFFFE}) begin
      nFails++;
      $display("FAIL edge_w0: got err=%b we=%b sel=%b addr=%h, expected 0 1 1 fffe",
               err, bif.mem_we, bif.mem_sel, bif.mem_addr);
    end
    applyStimulus(16'h0002);
    nChecks++;
    if ({bif.mem_we, bif.mem_addr, bif.mem_wdata} !== {1'b1, 16'hFFFF, 16'h0002}) begin
      nFails++;
      $display("FAIL edge_w1: got we=%b addr=%h wd=%h, expected 1 ffff 0002", bif.mem_we, bif.mem_addr, bif.mem_wdata);
    end
    applyStimulus(16'h0000);
    applyStimulus(16'hFFFD);
    nChecks++;
    if ({done, err} !== 2'b10) begin
      nFails++;
      $display("FAIL edge_done: got done=%b err=%b, expected 1 0", done, err);
    end
  endtask

  task automatic test_timeout();
    doReset();
    applyStimulus(16'h0004);
    applyStimulus(16'h0020);
    applyStimulus(16'h1234);
    idleCycles(7);
    nChecks++;
    if (err !== 1'b0) begin
      nFails++;
      $display("FAIL tmo_early: got err=%b after 7 idle cycles, expected 0", err);
    end
    idleCycles(1);
    nChecks++;
    if ({err, errCode, bif.in_ready, cpuRstN} !== {1'b1, 2'b11, 1'b0, 1'b0}) begin
      nFails++;
      $display("FAIL tmo_err: got err=%b code=%b rdy=%b cpu_rst_n=%b, expected 1 11 0 0",
               err, errCode, bif.in_ready, cpuRstN);
    end

    doReset();
    idleCycles(100);
    nChecks++;
    if ({err, bif.in_ready} !== 2'b01) begin
      nFails++;
      $display("FAIL hdr_stall: got err=%b rdy=%b, expected 0 1", err, bif.in_ready);
    end
    applyStimulus(16'h0001);
    applyStimulus(16'h0040);
    applyStimulus(16'h0100);
    idleCycles(100);
    applyStimulus(16'h0000);
    applyStimulus(16'hFF00);
    nChecks++;
    if ({done, err, wordsLoaded} !== {1'b1, 1'b0, 16'd1}) begin
      nFails++;
      $display("FAIL hdr_stall_done: got done=%b err=%b words=%h, expected 1 0 0001", done, err, wordsLoaded);
    end
  endtask

  task automatic test_reset_mid_data();
    doReset();
    applyStimulus(16'h0003);
    applyStimulus(16'h0010);
    applyStimulus(16'hAAAA);
    idleCycles(1);
    nChecks++;
    if (wordsLoaded !== 16'd1) begin
      nFails++;
      $display("FAIL mid_pre: got words=%h, expected 0001", wordsLoaded);
    end
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    nChecks++;
    if ({wordsLoaded, bif.mem_we, bif.in_ready, err, done, cpuRstN} !== {16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      nFails++;
      $display("FAIL mid_rst: got words=%h we=%b rdy=%b err=%b done=%b cpu_rst_n=%b, expected 0000 0 1 0 0 0",
               wordsLoaded, bif.mem_we, bif.in_ready, err, done, cpuRstN);
    end
    applyStimulus(16'h0003);
    applyStimulus(16'h0010);
    applyStimulus(16'hA1B2);
    applyStimulus(16'h0004);
    applyStimulus(16'h0005);
    applyStimulus(16'h0000);
    applyStimulus(16'h5E45);
    nChecks++;
    if ({done, cpuRstN, err, wordsLoaded} !== {1'b1, 1'b1, 1'b0, 16'd3}) begin
      nFails++;
      $display("FAIL mid_done: got done=%b cpu_rst_n=%b err=%b words=%h, expected 1 1 0 0003",
               done, cpuRstN, err, wordsLoaded);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails = 0;
    weCount = 0;
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data = 16'h0000;
    test_reset();
    test_single_section();
    test_two_sections_gap();
    test_bad_checksum();
    test_range();
    test_timeout();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
# boot_loader

Streams a program/data image into the CPU's instruction and data memories before execution, then releases the CPU from reset. Sits directly upstream of the `cpu` core: it owns the memory write ports during boot and drives the core's active-low reset. The image format is a sequence of sections closed by a checksum, so a corrupt or truncated image never starts the CPU.

## Interface
- `TIMEOUT`, default 1024: consecutive no-accept cycles tolerated mid-image before error; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  image word available on `in_data`.
- `in_data`  in  16  image word.
- `in_ready`  out  1  loader accepts a word; a transfer occurs when `in_valid & in_ready`.
- `mem_we`  out  1  memory write strobe (one word).
- `mem_sel`  out  1  write target: 0 = instruction memory, 1 = data memory.
- `mem_addr`  out  16  word address.
- `mem_wdata`  out  16  write data.
- `cpu_rst_n`  out  1  active-low reset to the CPU; low until the image is verified.
- `done`  out  1  image loaded and checksum good (sticky).
- `err`  out  1  load failed (sticky).
- `err_code`  out  2  01 = checksum, 10 = range/format, 11 = timeout; 00 when `err` = 0.
- `words_loaded`  out  16  count of data words written; saturates at 0xFFFF.

## Operation
- Image format: repeated sections {header, start address, N data words}, then end marker 0x0000, then checksum word.
- Header: bit15 = target (`mem_sel`), bits14:0 = N. 0x0000 = end marker. 0x8000 = range/format error.
- FSM states:
  - HDR: N ≠ 0 → ADDR; 0x0000 → CSUM; 0x8000 → ERR(10).
  - ADDR: latch start address A. If A + N > 0x10000 (17-bit compare) → ERR(10); else → DATA.
  - DATA: each accepted word is written at A, A+1, …; after the N-th word → HDR.
  - CSUM: accept the checksum word. If the 16-bit sum of all data words plus the checksum ≡ 0 (mod 2^16) → DONE, else → ERR(01).
  - DONE / ERR: terminal until `rst`.
- Header, address, end-marker and checksum words are not summed and not written.
- `in_ready` = 1 in HDR/ADDR/DATA/CSUM; 0 in DONE/ERR.
- Timeout: a counter increments on every cycle in ADDR/DATA/CSUM without a transfer, and clears on each transfer. When it reaches `TIMEOUT` → ERR(11). HDR is exempt, so waiting before or between sections is unbounded.
- Checksum sum and `words_loaded` accumulate across all sections.
- `rst` at any point, including mid-DATA:
  - state → HDR; sum, counters and address clear.
  - `cpu_rst_n` → 0; `done`, `err`, `mem_we` → 0; `err_code` → 00.
  - Memory contents are not touched.

## Timing
- Reset values: `in_ready` = 1, `mem_we` = 0, `mem_sel`/`mem_addr`/`mem_wdata` = 0, `cpu_rst_n` = 0, `done` = 0, `err` = 0, `err_code` = 00, `words_loaded` = 0. The reset value of `in_ready` is its post-reset value in HDR.
- Write path is registered: a data word accepted in cycle k produces `mem_we` = 1 with its `mem_addr`/`mem_wdata`/`mem_sel` in cycle k+1, for exactly one cycle. `words_loaded` increments in cycle k+1.
- Back-to-back transfers give one write per cycle with no bubbles.
- The checksum is accepted in cycle c. In cycle c+1:
  - on pass: `done` = 1 and `cpu_rst_n` = 1.
  - on fail: `err` = 1 with `err_code` = 01.
- The last data write always completes before `cpu_rst_n` rises, since at least the end-marker cycle intervenes.
- Error detection registers `err`/`err_code` the cycle after the offending accept, or the cycle after the timeout count is reached; `in_ready` drops in that same cycle.
- `cpu_rst_n` never rises once `err` = 1.

## Test plan
- Single instruction section 0x0003, 0x0010, 0xA1B2, 0x0004, 0x0005, 0x0000, 0x5E45 (continuous `in_valid`):
  - writes instr[0x10..0x12] = A1B2/0004/0005 on consecutive cycles;
  - then `done` = 1, `cpu_rst_n` = 1, `words_loaded` = 3.
- Instruction section (2 words @0x0000) plus data section 0x8002 @0x0100, with `in_valid` dropped for 3 cycles mid-section:
  - correct `mem_sel` per write; no spurious `mem_we` during the gaps; `done` with the correct checksum.
- Same image as the first scenario with checksum 0x5E44:
  - `err` = 1, `err_code` = 01, `cpu_rst_n` stays 0, `in_ready` = 0.
- Header 0x8004 with address 0xFFFE:
  - `err_code` = 10 the cycle after the address accept; zero `mem_we` pulses.
- `TIMEOUT` = 8, stall `in_valid` in DATA after the first word:
  - `err_code` = 11 after 8 idle cycles.
  - Repeat with the stall in HDR for 100 cycles: no error.
- `rst` pulsed mid-DATA, then a fresh valid image:
  - counters restart from 0 and `done` asserts.
  - The checksum covers only post-reset words.
